// File: rtl/command_responder_pkg.sv
// Shared types for the manager-link responder: command codes, response
// packet layout, FSM state encodings and the response builder.
package ResponderPkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int CMD_W  = 5;
  localparam int MSG_W  = 48;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 5'h00,
    CMD_WRITE = 5'h01,
    CMD_READ  = 5'h02,
    CMD_PING  = 5'h03,
    CMD_ERROR = 5'h1F
  } cmd_e;

  typedef struct packed {
    logic [2:0]        reserved;
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } response_t;

  localparam logic [DATA_W-1:0] PING_PATTERN = 32'hC0FF_EE00;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_READ_WAIT = 3'd2;
  localparam logic [2:0] ST_BUILD     = 3'd3;
  localparam logic [2:0] ST_WAIT_SENT = 3'd4;

  // Illegal commands answer with CMD_ERROR and carry the offending code.
  function automatic response_t build_response(
    input logic [CMD_W-1:0]  cmd,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] rdata
  );
    response_t r;
    r.reserved = 3'b000;
    r.addr     = addr;
    case (cmd)
      CMD_WRITE: begin
        r.command = CMD_WRITE;
        r.data    = wdata;
      end
      CMD_READ: begin
        r.command = CMD_READ;
        r.data    = rdata;
      end
      CMD_PING: begin
        r.command = CMD_PING;
        r.data    = PING_PATTERN;
      end
      default: begin
        r.command = CMD_ERROR;
        r.data    = {{(DATA_W-CMD_W){1'b0}}, cmd};
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/command_responder_sat_counter8.sv
// 8-bit event counter that sticks at 255 and clears synchronously.
module sat_counter8 (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_inc && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/command_responder.sv
// Responder end of the manager link: executes decoded packets against the
// register bank and returns one 48-bit response per non-NOP command.
module command_responder
  import ResponderPkg::*;
#(
  parameter int DATA_LENGTH   = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int COMMAND_WIDTH = 5,
  parameter int MSG_LENGTH    = 48,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     rsnt,
  input  logic                     packet_received,
  input  logic [COMMAND_WIDTH-1:0] command,
  input  logic [ADDRWIDTH-1:0]     reg_addr,
  input  logic [DATA_LENGTH-1:0]   rx_data,
  input  logic                     data_sent,
  output logic                     send_data,
  output logic [MSG_LENGTH-1:0]    tx_data,
  output logic                     reg_wr_en,
  output logic                     reg_rd_en,
  output logic [ADDRWIDTH-1:0]     reg_bus_addr,
  output logic [DATA_LENGTH-1:0]   reg_wdata,
  input  logic [DATA_LENGTH-1:0]   reg_rdata,
  output logic                     busy,
  output logic [7:0]               drop_count,
  output logic [7:0]               timeout_count,
  output logic [2:0]               dbg_state
);

  // Handshake: send_data holds tx_data stable until data_sent is seen in
  // WAIT_SENT (or the timer abandons it); data_sent elsewhere is ignored.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [2:0]               r_state;
  logic [2:0]               w_next_state;
  logic [COMMAND_WIDTH-1:0] r_cmd;
  logic [ADDRWIDTH-1:0]     r_addr;
  logic [DATA_LENGTH-1:0]   r_data;
  logic [DATA_LENGTH-1:0]   r_rdata;
  logic [TIMER_W-1:0]       r_timer;
  logic                     r_send;
  logic [MSG_LENGTH-1:0]    r_tx;
  logic                     r_wr_en;
  logic                     r_rd_en;
  logic [ADDRWIDTH-1:0]     r_bus_addr;
  logic [DATA_LENGTH-1:0]   r_wdata;
  logic                     r_busy;

  logic w_timer_done;
  logic w_drop_inc;
  logic w_timeout_inc;

  assign w_timer_done  = (r_timer == TIMER_LAST);
  assign w_drop_inc    = packet_received && (r_state != ST_IDLE);
  // data_sent on the abandon edge takes priority and is not a timeout.
  assign w_timeout_inc = (r_state == ST_WAIT_SENT) && !data_sent && w_timer_done;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (packet_received) w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (r_cmd)
          CMD_NOP:  w_next_state = ST_IDLE;
          CMD_READ: w_next_state = ST_READ_WAIT;
          default:  w_next_state = ST_BUILD;
        endcase
      end
      ST_READ_WAIT: w_next_state = ST_BUILD;
      ST_BUILD:     w_next_state = ST_WAIT_SENT;
      ST_WAIT_SENT: if (data_sent || w_timer_done) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsnt) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rdata    <= '0;
      r_timer    <= '0;
      r_send     <= 1'b0;
      r_tx       <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_bus_addr <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (packet_received) begin
            r_cmd  <= command;
            r_addr <= reg_addr;
            r_data <= rx_data;
          end
        end
        ST_DECODE: begin
          if (r_cmd == CMD_WRITE) begin
            r_wr_en    <= 1'b1;
            r_bus_addr <= r_addr;
            r_wdata    <= r_data;
          end else if (r_cmd == CMD_READ) begin
            r_rd_en    <= 1'b1;
            r_bus_addr <= r_addr;
          end
        end
        ST_READ_WAIT: r_rdata <= reg_rdata;
        ST_BUILD: begin
          r_tx    <= build_response(r_cmd, r_addr, r_data, r_rdata);
          r_send  <= 1'b1;
          r_timer <= '0;
        end
        ST_WAIT_SENT: begin
          if (data_sent || w_timer_done) begin
            r_send <= 1'b0;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter8 u_drop_counter (
    .clk     (clk),
    .i_clr   (rsnt),
    .i_inc   (w_drop_inc),
    .o_count (drop_count)
  );

  sat_counter8 u_timeout_counter (
    .clk     (clk),
    .i_clr   (rsnt),
    .i_inc   (w_timeout_inc),
    .o_count (timeout_count)
  );

  assign send_data    = r_send;
  assign tx_data      = r_tx;
  assign reg_wr_en    = r_wr_en;
  assign reg_rd_en    = r_rd_en;
  assign reg_bus_addr = r_bus_addr;
  assign reg_wdata    = r_wdata;
  assign busy         = r_busy;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_command_responder.sv
// Directed bench for command_responder with a short response timeout.
module tb_command_responder;

  logic        clk = 1'b0;
  logic        rsnt;
  logic        packet_received;
  logic [4:0]  command;
  logic [7:0]  reg_addr;
  logic [31:0] rx_data;
  logic        data_sent;
  logic        send_data;
  logic [47:0] tx_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_bus_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        busy;
  logic [7:0]  drop_count;
  logic [7:0]  timeout_count;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  command_responder #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rsnt            (rsnt),
    .packet_received (packet_received),
    .command         (command),
    .reg_addr        (reg_addr),
    .rx_data         (rx_data),
    .data_sent       (data_sent),
    .send_data       (send_data),
    .tx_data         (tx_data),
    .reg_wr_en       (reg_wr_en),
    .reg_rd_en       (reg_rd_en),
    .reg_bus_addr    (reg_bus_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .busy            (busy),
    .drop_count      (drop_count),
    .timeout_count   (timeout_count),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle packet pulse; returns after edge k.
  task automatic send_packet(input logic [4:0] cmd, input logic [7:0] addr, input logic [31:0] data);
    packet_received = 1'b1;
    command         = cmd;
    reg_addr        = addr;
    rx_data         = data;
    tick();
    packet_received = 1'b0;
  endtask

  task automatic ack();
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
  endtask

  initial begin
    rsnt            = 1'b1;
    packet_received = 1'b0;
    command         = '0;
    reg_addr        = '0;
    rx_data         = '0;
    data_sent       = 1'b0;
    reg_rdata       = '0;
    tick();
    tick();
    check("reset_send", 48'(send_data), 48'd0);
    check("reset_tx", tx_data, 48'd0);
    check("reset_strobes", 48'({reg_wr_en, reg_rd_en}), 48'd0);
    check("reset_bus", 48'({reg_bus_addr, reg_wdata}), 48'd0);
    check("reset_counters", 48'({drop_count, timeout_count}), 48'd0);
    check("reset_busy", 48'(busy), 48'd0);
    check("reset_state", 48'(dbg_state), 48'd0);
    rsnt = 1'b0;
    tick();

    // WRITE
    send_packet(5'h01, 8'h10, 32'hDEAD_BEEF);
    check("wr_k_busy", 48'(busy), 48'd1);
    check("wr_k_nostrobe", 48'(reg_wr_en), 48'd0);
    tick();
    check("wr_strobe", 48'({reg_wr_en, reg_rd_en}), 48'b10);
    check("wr_bus", 48'({reg_bus_addr, reg_wdata}), 48'h10_DEADBEEF);
    check("wr_send_early", 48'(send_data), 48'd0);
    tick();
    check("wr_strobe_once", 48'(reg_wr_en), 48'd0);
    check("wr_send", 48'(send_data), 48'd1);
    check("wr_tx", tx_data, 48'h01_10_DEADBEEF);
    ack();
    check("wr_ack_send", 48'(send_data), 48'd0);
    check("wr_ack_busy", 48'(busy), 48'd0);

    // READ, plus a dropped packet while waiting for data_sent
    send_packet(5'h02, 8'h04, 32'h0);
    tick();
    check("rd_strobe", 48'({reg_wr_en, reg_rd_en}), 48'b01);
    check("rd_addr", 48'(reg_bus_addr), 48'h04);
    reg_rdata = 32'h1234_5678;
    tick();
    check("rd_send_early", 48'(send_data), 48'd0);
    check("rd_strobe_once", 48'(reg_rd_en), 48'd0);
    reg_rdata = 32'hFFFF_FFFF;
    tick();
    check("rd_send", 48'(send_data), 48'd1);
    check("rd_tx", tx_data, 48'h02_04_12345678);
    send_packet(5'h01, 8'h99, 32'h1111_1111);
    exp_drop = 1;
    check("drop_one", 48'(drop_count), 48'(exp_drop));
    check("drop_no_strobe", 48'(reg_wr_en), 48'd0);
    check("drop_tx_stable", tx_data, 48'h02_04_12345678);
    tick();
    check("drop_no_strobe2", 48'(reg_wr_en), 48'd0);
    ack();
    check("rd_ack_send", 48'(send_data), 48'd0);

    // PING accepted on the edge right after data_sent
    send_packet(5'h03, 8'h55, 32'h0);
    check("ping_accept", 48'(busy), 48'd1);
    check("ping_drop_same", 48'(drop_count), 48'(exp_drop));
    tick();
    check("ping_no_strobe", 48'({reg_wr_en, reg_rd_en}), 48'd0);
    tick();
    check("ping_tx", tx_data, 48'h03_55_C0FFEE00);
    ack();

    // Illegal command
    send_packet(5'h07, 8'h22, 32'hAAAA_AAAA);
    tick();
    check("ill_no_strobe", 48'({reg_wr_en, reg_rd_en}), 48'd0);
    tick();
    check("ill_send", 48'(send_data), 48'd1);
    check("ill_tx", tx_data, 48'h1F_22_00000007);
    ack();

    // NOP: no response, back to idle
    send_packet(5'h00, 8'h33, 32'h0);
    check("nop_busy", 48'(busy), 48'd1);
    tick();
    check("nop_idle", 48'(busy), 48'd0);
    tick();
    check("nop_no_send", 48'(send_data), 48'd0);
    check("nop_no_strobe", 48'({reg_wr_en, reg_rd_en}), 48'd0);

    // Timeout: send_data drops 16 edges after rising
    send_packet(5'h03, 8'h01, 32'h0);
    tick();
    tick();
    check("to_send", 48'(send_data), 48'd1);
    repeat (15) tick();
    check("to_still_send", 48'(send_data), 48'd1);
    check("to_count_pre", 48'(timeout_count), 48'd0);
    tick();
    check("to_dropped", 48'(send_data), 48'd0);
    check("to_count", 48'(timeout_count), 48'd1);
    check("to_idle", 48'(busy), 48'd0);

    // data_sent on the abandon edge wins; a stray data_sent in IDLE is ignored
    send_packet(5'h03, 8'h02, 32'h0);
    tick();
    tick();
    repeat (15) tick();
    check("race_send", 48'(send_data), 48'd1);
    data_sent = 1'b1;
    tick();
    check("race_dropped", 48'(send_data), 48'd0);
    check("race_count", 48'(timeout_count), 48'd1);
    tick();
    data_sent = 1'b0;
    check("stray_ack_idle", 48'({busy, send_data}), 48'd0);

    // Drop-count saturation: 14 dropped packets per round, 22 rounds
    for (int r = 0; r < 22; r++) begin
      send_packet(5'h03, 8'h03, 32'h0);
      packet_received = 1'b1;
      repeat (14) tick();
      packet_received = 1'b0;
      ack();
      exp_drop = (exp_drop + 14 > 255) ? 255 : exp_drop + 14;
      check("drop_sat", 48'(drop_count), 48'(exp_drop));
    end
    check("drop_final", 48'(drop_count), 48'd255);
    check("to_unchanged", 48'(timeout_count), 48'd1);

    // Reset while in READ_WAIT
    send_packet(5'h02, 8'h08, 32'h0);
    tick();
    check("rst_rd_strobe", 48'(reg_rd_en), 48'd1);
    rsnt = 1'b1;
    tick();
    rsnt = 1'b0;
    check("rst_send", 48'(send_data), 48'd0);
    check("rst_tx", tx_data, 48'd0);
    check("rst_strobes", 48'({reg_wr_en, reg_rd_en}), 48'd0);
    check("rst_bus", 48'({reg_bus_addr, reg_wdata}), 48'd0);
    check("rst_counters", 48'({drop_count, timeout_count}), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    tick();
    tick();
    check("rst_no_send", 48'({send_data, busy, reg_rd_en}), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
